// File: rtl/bundle_issue_ctrl_pkg.sv
// Shared definitions for the dual-slot bundle issue controller.
// Contents: bundle field positions, slot opcode/func codes, controller
// state enum, pc_src encodings, flag strobe indices and per-slot control
// vector types.
package bundle_pkg;

  // Bundle field LSB positions
  localparam int S1_OP_LSB   = 0;   // slot 1 op   [4:0]
  localparam int S1_FUNC_LSB = 5;   // slot 1 func [7:5]
  localparam int S1_RD_LSB   = 8;   // slot 1 rd   [10:8]
  localparam int S2_OP_LSB   = 16;  // slot 2 op   [20:16]
  localparam int S2_RS_LSB   = 24;  // slot 2 rs   [26:24]

  // Slot 1 opcodes and ALU-reg func codes
  localparam logic [4:0] OP1_ALU_REG = 5'b01000;
  localparam logic [4:0] OP1_ALU_IMM = 5'b00101;
  localparam logic [4:0] OP1_NOP     = 5'b00000;
  localparam logic [2:0] FUNC_ARITH  = 3'b100;  // alu_op 00, writes c+v
  localparam logic [2:0] FUNC_SHIFT  = 3'b011;  // alu_op 11, writes c
  localparam logic [2:0] FUNC_LOGIC  = 3'b010;  // alu_op 10, no c/v

  // Slot 2 opcodes
  localparam logic [4:0] OP2_LOAD   = 5'b01010;
  localparam logic [4:0] OP2_STORE  = 5'b01011;
  localparam logic [4:0] OP2_JUMP   = 5'b11110;
  localparam logic [4:0] OP2_BRANCH = 5'b11011;
  localparam logic [4:0] OP2_NOP    = 5'b00000;

  // pc_src encodings
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Flag strobe bit indices within {z,n,c,v}
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SPLIT,
    ST_MEM
  } state_t;

  typedef struct packed {
    logic       reg_write;
    logic [3:0] flag_we;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic       alu_src_b;
  } slot1_ctrl_t;

  typedef struct packed {
    logic load;
    logic store;
    logic jump;
    logic branch;
  } slot2_ctrl_t;

  function automatic logic [3:0] flag_bit(input int idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/bundle_issue_ctrl_if.sv
// Handshake/control bundle between the issue controller and its
// neighbours (fetch register, register file, ALU, flag register, data
// memory port).
//   master: the controller (drives strobes, ir_ready, mem_req/mem_we)
//   slave : the datapath / environment side
interface bundle_issue_ctrl_if;
  logic        ir_valid;
  logic [31:0] ir;
  logic        ir_ready;
  logic        branch_taken;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic        reg_write1;
  logic        reg_write2;
  logic [3:0]  flag_we1;
  logic [3:0]  flag_we2;
  logic [1:0]  alu_op;
  logic        alu_src_a;
  logic        alu_src_b;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        illegal;
  logic        mem_err;

  modport master (
    input  ir_valid, ir, branch_taken, mem_ack,
    output ir_ready, mem_req, mem_we, reg_write1, reg_write2,
           flag_we1, flag_we2, alu_op, alu_src_a, alu_src_b,
           pc_write, pc_src, illegal, mem_err
  );

  modport slave (
    output ir_valid, ir, branch_taken, mem_ack,
    input  ir_ready, mem_req, mem_we, reg_write1, reg_write2,
           flag_we1, flag_we2, alu_op, alu_src_a, alu_src_b,
           pc_write, pc_src, illegal, mem_err
  );
endinterface

// File: rtl/bundle_issue_ctrl_slot_decode.sv
// slot_decode: combinational decode of one 32-bit bundle.
// Ports:
//   bundle  in  32  latched bundle
//   s1      out     slot 1 register/flag/ALU controls (zero when nop/illegal)
//   s2      out     slot 2 kind (load/store/jump/branch, all zero for nop)
//   illegal out 1   either slot carries an undecodable op/func
//   hazard  out 1   slot 2 load/store reads the register slot 1 writes
module slot_decode
  import bundle_pkg::*;
(
  input  logic [31:0] bundle,
  output slot1_ctrl_t s1,
  output slot2_ctrl_t s2,
  output logic        illegal,
  output logic        hazard
);

  logic [4:0] op1;
  logic [2:0] func1;
  logic [2:0] rd1;
  logic [4:0] op2;
  logic [2:0] rs2;
  logic       ill1;
  logic       ill2;

  assign op1   = bundle[S1_OP_LSB   +: 5];
  assign func1 = bundle[S1_FUNC_LSB +: 3];
  assign rd1   = bundle[S1_RD_LSB   +: 3];
  assign op2   = bundle[S2_OP_LSB   +: 5];
  assign rs2   = bundle[S2_RS_LSB   +: 3];

  // Reserved bundle bits carry no meaning for this controller.
  logic unused_bits;
  assign unused_bits = ^{bundle[15:11], bundle[23:21], bundle[31:27]};

  always_comb begin
    s1   = '0;
    ill1 = 1'b0;
    case (op1)
      OP1_ALU_REG: begin
        case (func1)
          FUNC_ARITH: begin
            s1.reg_write = 1'b1;
            s1.alu_op    = 2'b00;
            s1.flag_we   = flag_bit(FLAG_Z) | flag_bit(FLAG_N) |
                           flag_bit(FLAG_C) | flag_bit(FLAG_V);
          end
          FUNC_SHIFT: begin
            s1.reg_write = 1'b1;
            s1.alu_op    = 2'b11;
            s1.flag_we   = flag_bit(FLAG_Z) | flag_bit(FLAG_N) | flag_bit(FLAG_C);
          end
          FUNC_LOGIC: begin
            s1.reg_write = 1'b1;
            s1.alu_op    = 2'b10;
            s1.flag_we   = flag_bit(FLAG_Z) | flag_bit(FLAG_N);
          end
          default: ill1 = 1'b1;  // unknown func degrades to nop
        endcase
      end
      OP1_ALU_IMM: begin
        s1.alu_op    = 2'b01;
        s1.alu_src_a = 1'b1;
        s1.alu_src_b = 1'b1;
        s1.flag_we   = flag_bit(FLAG_Z) | flag_bit(FLAG_N) |
                       flag_bit(FLAG_C) | flag_bit(FLAG_V);
      end
      OP1_NOP: ;
      default: ill1 = 1'b1;
    endcase
  end

  always_comb begin
    s2   = '0;
    ill2 = 1'b0;
    case (op2)
      OP2_LOAD:   s2.load   = 1'b1;
      OP2_STORE:  s2.store  = 1'b1;
      OP2_JUMP:   s2.jump   = 1'b1;
      OP2_BRANCH: s2.branch = 1'b1;
      OP2_NOP:    ;
      default:    ill2 = 1'b1;
    endcase
  end

  assign illegal = ill1 | ill2;
  // The memory op's address register must see slot 1's result, so the
  // bundle is split when slot 2 reads the register slot 1 is writing.
  assign hazard  = s1.reg_write & (s2.load | s2.store) & (rs2 == rd1);

endmodule

// File: rtl/bundle_issue_ctrl.sv
// bundle_issue_ctrl: sequences one dual-slot bundle at a time from the
// fetch register into register-file, flag, ALU, memory and PC controls.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset
//   bus  master modport of bundle_issue_ctrl_if (fetch handshake,
//        datapath strobes, mem_req/mem_ack handshake, illegal, mem_err)
// Parameter MEM_TIMEOUT (2..255): unanswered mem_req cycles before abort.
// Optional feature macro BUNDLE_CTRL_TIMEOUT_EN: when defined, MEM aborts
// after MEM_TIMEOUT cycles without mem_ack and pulses mem_err; when
// undefined, MEM waits indefinitely and mem_err stays 0.
module bundle_issue_ctrl
  import bundle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  bundle_issue_ctrl_if.master bus
);

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] bundle_reg;
  slot1_ctrl_t s1;
  slot2_ctrl_t s2;
  logic        dec_illegal;
  logic        dec_hazard;
  logic        timeout;
  logic [3:0]  flag_we1_raw;
  logic [3:0]  flag_we2_v;
  logic [1:0]  s2_pc_src;

  slot_decode u_decode (
    .bundle  (bundle_reg),
    .s1      (s1),
    .s2      (s2),
    .illegal (dec_illegal),
    .hazard  (dec_hazard)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      bundle_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && bus.ir_valid)
        bundle_reg <= bus.ir;
    end
  end

`ifdef BUNDLE_CTRL_TIMEOUT_EN
  // Counts completed MEM cycles; zero on the first MEM cycle, so the abort
  // cycle follows exactly MEM_TIMEOUT cycles of mem_req.
  logic [7:0] wait_cnt_reg;
  always_ff @(posedge clk) begin
    if (rst || state_reg != ST_MEM)
      wait_cnt_reg <= '0;
    else
      wait_cnt_reg <= wait_cnt_reg + 8'd1;
  end
  assign timeout = (state_reg == ST_MEM) && (wait_cnt_reg == 8'(MEM_TIMEOUT));
`else
  localparam int unused_mem_timeout = MEM_TIMEOUT;
  assign timeout = 1'b0;
`endif

  // Slot 2 PC selection; branch_taken only matters in the branch's final cycle.
  assign s2_pc_src = s2.jump                      ? PC_JUMP   :
                     (s2.branch && bus.branch_taken) ? PC_BRANCH : PC_SEQ;

  always_comb begin
    state_next     = state_reg;
    bus.ir_ready   = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.reg_write1 = 1'b0;
    bus.reg_write2 = 1'b0;
    bus.alu_op     = 2'b00;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = PC_SEQ;
    bus.illegal    = 1'b0;
    bus.mem_err    = 1'b0;
    flag_we1_raw   = 4'b0000;
    flag_we2_v     = 4'b0000;

    case (state_reg)
      ST_IDLE: begin
        bus.ir_ready = 1'b1;
        if (bus.ir_valid) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        bus.reg_write1 = s1.reg_write;
        flag_we1_raw   = s1.flag_we;
        bus.alu_op     = s1.alu_op;
        bus.alu_src_a  = s1.alu_src_a;
        bus.alu_src_b  = s1.alu_src_b;
        bus.illegal    = dec_illegal;
        if (dec_hazard) begin
          state_next = ST_SPLIT;
        end else if (s2.load || s2.store) begin
          state_next = ST_MEM;
        end else begin
          bus.pc_write = 1'b1;
          bus.pc_src   = s2_pc_src;
          state_next   = ST_IDLE;
        end
      end
      ST_SPLIT: begin
        // Memory controls only start in MEM, so a split cycle is quiet.
        if (s2.load || s2.store) begin
          state_next = ST_MEM;
        end else begin
          bus.pc_write = 1'b1;
          bus.pc_src   = s2_pc_src;
          state_next   = ST_IDLE;
        end
      end
      ST_MEM: begin
        if (timeout) begin
          bus.mem_err  = 1'b1;
          bus.pc_write = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          bus.mem_req = 1'b1;
          bus.mem_we  = s2.store;
          if (bus.mem_ack) begin
            if (s2.load) begin
              bus.reg_write2 = 1'b1;
              flag_we2_v     = flag_bit(FLAG_Z) | flag_bit(FLAG_N);
            end
            bus.pc_write = 1'b1;
            state_next   = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Slot 2 owns any flag both slots strobe in the same cycle.
    bus.flag_we1 = flag_we1_raw & ~flag_we2_v;
    bus.flag_we2 = flag_we2_v;

    // A reset cycle aborts the bundle: no write, PC or event strobes.
    if (rst) begin
      bus.reg_write1 = 1'b0;
      bus.reg_write2 = 1'b0;
      bus.flag_we1   = 4'b0000;
      bus.flag_we2   = 4'b0000;
      bus.pc_write   = 1'b0;
      bus.illegal    = 1'b0;
      bus.mem_err    = 1'b0;
    end
  end

endmodule

// File: tb/tb_bundle_issue_ctrl.sv
// Self-checking bench for bundle_issue_ctrl: vector table, directed
// multi-cycle corner cases, and randomized bundles against a cycle-list
// reference model built from the decode/sequencing rules.
module tb_bundle_issue_ctrl;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bundle_issue_ctrl_if bus();

  bundle_issue_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       ir_ready;
    logic       mem_req;
    logic       mem_we;
    logic       rw1;
    logic       rw2;
    logic [3:0] f1;
    logic [3:0] f2;
    logic [1:0] alu_op;
    logic       sa;
    logic       sb;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       illegal;
    logic       mem_err;
  } obs_t;

  typedef struct {
    obs_t exp;
    logic ack;
    logic taken;
  } cyc_t;

  typedef struct {
    logic [31:0] ir;
    logic        taken;
    int          ack_at;
    int          len;
    logic [1:0]  pcs;
    logic        ill;
    logic        rw1;
    logic        rw2;
    logic [3:0]  f1;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  cyc_t exp_q[$];
  vec_t vt[14];

  function automatic obs_t sample();
    obs_t o;
    o.ir_ready = bus.ir_ready;  o.mem_req = bus.mem_req; o.mem_we = bus.mem_we;
    o.rw1 = bus.reg_write1;     o.rw2 = bus.reg_write2;
    o.f1 = bus.flag_we1;        o.f2 = bus.flag_we2;    o.alu_op = bus.alu_op;
    o.sa = bus.alu_src_a;       o.sb = bus.alu_src_b;
    o.pc_write = bus.pc_write;  o.pc_src = bus.pc_src;
    o.illegal = bus.illegal;    o.mem_err = bus.mem_err;
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o = '0;
    o.ir_ready = 1'b1;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected per-cycle outputs (cycles 1..end) for one
  // bundle, from the decode rules and the slot sequencing rules.
  task automatic model_bundle(input logic [31:0] ir, input int ack_at);
    logic [4:0] o1, o2;
    logic [2:0] fn, rd, rs;
    logic       wr, bad1, bad2, ld, st, jp, br, split, mem, tk;
    logic [3:0] fl;
    logic [1:0] alu;
    logic       src;
    cyc_t       c;
    o1 = ir[4:0]; fn = ir[7:5]; rd = ir[10:8]; o2 = ir[20:16]; rs = ir[26:24];
    wr = 0; bad1 = 0; fl = 0; alu = 0; src = 0;
    if (o1 == 5'd8) begin
      if (fn == 3'd4)      begin wr = 1; fl = 4'b1111; alu = 2'd0; end
      else if (fn == 3'd3) begin wr = 1; fl = 4'b1110; alu = 2'd3; end
      else if (fn == 3'd2) begin wr = 1; fl = 4'b1100; alu = 2'd2; end
      else bad1 = 1;
    end else if (o1 == 5'd5) begin
      fl = 4'b1111; alu = 2'd1; src = 1;
    end else if (o1 != 5'd0) begin
      bad1 = 1;
    end
    ld = (o2 == 5'd10); st = (o2 == 5'd11); jp = (o2 == 5'd30); br = (o2 == 5'd27);
    bad2  = !(ld || st || jp || br || o2 == 5'd0);
    mem   = ld || st;
    split = wr && mem && (rs == rd);

    tk = 1'($urandom);
    c.exp = '0; c.exp.rw1 = wr; c.exp.f1 = fl; c.exp.alu_op = alu;
    c.exp.sa = src; c.exp.sb = src; c.exp.illegal = bad1 | bad2;
    if (!mem) begin
      c.exp.pc_write = 1;
      c.exp.pc_src = jp ? 2'b10 : ((br && tk) ? 2'b01 : 2'b00);
    end
    c.ack = 1'($urandom); c.taken = tk;   // ack outside MEM must be ignored
    exp_q.push_back(c);
    if (split) begin
      c.exp = '0; c.ack = 1'($urandom); c.taken = 1'($urandom);
      exp_q.push_back(c);
    end
    if (mem) begin
      for (int k = 1; k <= ack_at; k++) begin
        c.exp = '0; c.exp.mem_req = 1; c.exp.mem_we = st;
        c.ack = (k == ack_at); c.taken = 1'($urandom);
        if (k == ack_at) begin
          c.exp.rw2 = ld; c.exp.f2 = ld ? 4'b1100 : 4'b0000; c.exp.pc_write = 1;
        end
        c.exp.f1 = c.exp.f1 & ~c.exp.f2;
        exp_q.push_back(c);
      end
    end
  endtask

  task automatic run_model(input logic [31:0] ir, input int ack_at, input int idx);
    cyc_t c;
    int   n = 0;
    exp_q.delete();
    model_bundle(ir, ack_at);
    bus.ir = ir; bus.ir_valid = 1; bus.mem_ack = 1'($urandom); bus.branch_taken = 1'($urandom);
    @(negedge clk);
    chk($sformatf("rnd%0d_accept", idx), 32'(sample()), 32'(idle_obs()));
    tick();
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      n++;
      bus.ir_valid = 1'($urandom); bus.ir = $urandom;
      bus.mem_ack = c.ack; bus.branch_taken = c.taken;
      @(negedge clk);
      chk($sformatf("rnd%0d_cyc%0d", idx, n), 32'(sample()), 32'(c.exp));
      tick();
    end
    bus.ir_valid = 0; bus.mem_ack = 0;
    $display("txn rnd%0d ir=%08h ack_at=%0d cycles=%0d", idx, ir, ack_at, n);
  endtask

  // Drives one bundle, answering the ack_at-th mem_req cycle, and
  // summarizes what the DUT did (bounded at 64 cycles).
  task automatic run_vec(input vec_t v, output int len, output logic [1:0] pcs,
                         output logic ill, output logic rw1, output logic rw2,
                         output logic [3:0] f1);
    obs_t o;
    int   memc = 0;
    bit   done = 0;
    len = 0; pcs = 2'b11; ill = 0; rw1 = 0; rw2 = 0; f1 = 0;
    bus.ir = v.ir; bus.ir_valid = 1; bus.branch_taken = v.taken; bus.mem_ack = 0;
    @(negedge clk);
    tick();
    bus.ir_valid = 0; bus.ir = $urandom;
    for (int c = 1; c < 64 && !done; c++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        memc++;
        bus.mem_ack = (memc == v.ack_at);
      end
      #1;
      o = sample();
      ill |= o.illegal; rw1 |= o.rw1; rw2 |= o.rw2; f1 |= o.f1;
      if (o.pc_write) begin done = 1; len = c; pcs = o.pc_src; end
      tick();
      bus.mem_ack = 0;
    end
  endtask

  function automatic logic [31:0] gen_ir();
    logic [31:0] r;
    logic [2:0]  rd;
    r = $urandom;
    case ($urandom_range(0, 4))
      0, 1: r[4:0] = 5'b01000;
      2:    r[4:0] = 5'b00101;
      3:    r[4:0] = 5'b00000;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: r[7:5] = 3'b100;
      1: r[7:5] = 3'b011;
      2: r[7:5] = 3'b010;
      default: ;
    endcase
    case ($urandom_range(0, 6))
      0, 1: r[20:16] = 5'b01010;
      2:    r[20:16] = 5'b01011;
      3:    r[20:16] = 5'b11110;
      4:    r[20:16] = 5'b11011;
      5:    r[20:16] = 5'b00000;
      default: ;
    endcase
    rd = r[10:8];
    if ($urandom_range(0, 1) == 1) r[26:24] = rd;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t e;
    int   len;
    logic [1:0] pcs;
    logic ill, rw1, rw2;
    logic [3:0] f1;

    //        ir            tk  ack len pcs    ill rw1 rw2 f1
    vt[0]  = '{32'h00000000, 0, 1, 1, 2'b00, 0, 0, 0, 4'b0000};
    vt[1]  = '{32'h020A0388, 0, 2, 3, 2'b00, 0, 1, 1, 4'b1111};
    vt[2]  = '{32'h030A0388, 0, 1, 3, 2'b00, 0, 1, 1, 4'b1111};
    vt[3]  = '{32'h001B0000, 1, 1, 1, 2'b01, 0, 0, 0, 4'b0000};
    vt[4]  = '{32'h001B0000, 0, 1, 1, 2'b00, 0, 0, 0, 4'b0000};
    vt[5]  = '{32'h001E0000, 0, 1, 1, 2'b10, 0, 0, 0, 4'b0000};
    vt[6]  = '{32'h000000E8, 0, 1, 1, 2'b00, 1, 0, 0, 4'b0000};
    vt[7]  = '{32'h000B0025, 0, 1, 2, 2'b00, 0, 0, 0, 4'b1111};
    vt[8]  = '{32'h00000368, 0, 1, 1, 2'b00, 0, 1, 0, 4'b1110};
    vt[9]  = '{32'h00000348, 0, 1, 1, 2'b00, 0, 1, 0, 4'b1100};
    vt[10] = '{32'h00010000, 0, 1, 1, 2'b00, 1, 0, 0, 4'b0000};
    vt[11] = '{32'h030B0388, 0, 3, 5, 2'b00, 0, 1, 0, 4'b1111};
    vt[12] = '{32'h031B0388, 1, 1, 1, 2'b01, 0, 1, 0, 4'b1111};
    vt[13] = '{32'h021E0025, 0, 1, 1, 2'b10, 0, 0, 0, 4'b1111};

    bus.ir_valid = 0; bus.ir = 0; bus.branch_taken = 0; bus.mem_ack = 0;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    chk("reset_in_rst", 32'(sample()), 32'(idle_obs()));
    tick();
    rst = 0;
    @(negedge clk);
    chk("reset_after", 32'(sample()), 32'(idle_obs()));
    tick();

    // Vector table
    for (int i = 0; i < 14; i++) begin
      run_vec(vt[i], len, pcs, ill, rw1, rw2, f1);
      chk($sformatf("vec%0d_len", i), 32'(len), 32'(vt[i].len));
      chk($sformatf("vec%0d_pc_src", i), 32'(pcs), 32'(vt[i].pcs));
      chk($sformatf("vec%0d_illegal", i), 32'(ill), 32'(vt[i].ill));
      chk($sformatf("vec%0d_reg_write1", i), 32'(rw1), 32'(vt[i].rw1));
      chk($sformatf("vec%0d_reg_write2", i), 32'(rw2), 32'(vt[i].rw2));
      chk($sformatf("vec%0d_flag_we1", i), 32'(f1), 32'(vt[i].f1));
      @(negedge clk);
      chk($sformatf("vec%0d_back_idle", i), 32'(sample()), 32'(idle_obs()));
      tick();
      $display("txn vec%0d ir=%08h len=%0d pc_src=%0d", i, vt[i].ir, len, pcs);
    end

    // Cycle-exact directed runs through the model
    run_model(32'h020A0388, 2, 900);
    run_model(32'h030A0388, 3, 901);

    // Unanswered memory request
    bus.ir = 32'h000B0025; bus.ir_valid = 1; bus.mem_ack = 0;
    @(negedge clk);
    tick();
    bus.ir_valid = 0;
    e = '0; e.f1 = 4'b1111; e.alu_op = 2'b01; e.sa = 1; e.sb = 1;
    @(negedge clk);
    chk("stall_exec", 32'(sample()), 32'(e));
    tick();
`ifdef BUNDLE_CTRL_TIMEOUT_EN
    e = '0; e.mem_req = 1; e.mem_we = 1;
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      chk($sformatf("tmo_wait%0d", k), 32'(sample()), 32'(e));
      tick();
    end
    e = '0; e.mem_err = 1; e.pc_write = 1;
    @(negedge clk);
    chk("tmo_abort", 32'(sample()), 32'(e));
    tick();
`else
    e = '0; e.mem_req = 1; e.mem_we = 1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk($sformatf("wait%0d", k), 32'(sample()), 32'(e));
      tick();
    end
    bus.mem_ack = 1;
    e.pc_write = 1;
    @(negedge clk);
    chk("late_ack", 32'(sample()), 32'(e));
    tick();
    bus.mem_ack = 0;
`endif
    @(negedge clk);
    chk("stall_back_idle", 32'(sample()), 32'(idle_obs()));
    tick();
    $display("txn stall ir=000b0025 no ack");

    // Reset in the 5th MEM cycle, with a coinciding mem_ack
    bus.ir = 32'h000B0025; bus.ir_valid = 1;
    @(negedge clk);
    tick();
    bus.ir_valid = 0;
    repeat (5) tick();           // EXEC + MEM cycles 1..4
    rst = 1; bus.mem_ack = 1;    // MEM cycle 5
    @(negedge clk);
    chk("rst_mem_no_pc_write", 32'(bus.pc_write), 32'd0);
    chk("rst_mem_no_mem_err", 32'(bus.mem_err), 32'd0);
    tick();
    rst = 0; bus.mem_ack = 0;
    @(negedge clk);
    chk("rst_mem_abort", 32'(sample()), 32'(idle_obs()));
    tick();
    $display("txn reset_in_mem ir=000b0025");

    // Randomized bundles against the model
    for (int n = 0; n < 60; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bus.ir_valid = 0; bus.mem_ack = 1'($urandom);
        @(negedge clk);
        chk($sformatf("rnd%0d_gap%0d", n, g), 32'(sample()), 32'(idle_obs()));
        tick();
      end
      run_model(gen_ir(), $urandom_range(1, 4), n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
